// File: rtl/factorization_checker_seq_if.sv
// Handshake/bus bundle for the sequential factorization checker.
// The requester drives start and the operands; the checker returns status and result.
interface factorization_checker_seq_if #(
   parameter int W = 4
);
   logic           start;
   logic [W-1:0]   i1;
   logic [W-1:0]   i2;
   logic [2*W-1:0] o;
   logic           busy;
   logic           done;
   logic           res;
   logic [2*W-1:0] product;

   modport master (
      output start, i1, i2, o,
      input  busy, done, res, product
   );

   modport slave (
      input  start, i1, i2, o,
      output busy, done, res, product
   );
endinterface

// File: rtl/factorization_checker_seq.sv
// Sequential factorization checker: a W-cycle shift-add multiplier computes i1*i2
// and compares the product against the claimed value o.
// Optional nontrivial check (rejects factor 1) and early exit once the multiplier
// has no set bits left.
module factorization_checker_seq #(
   parameter int W          = 4,
   parameter int NONTRIVIAL = 0,
   parameter int EARLY_EXIT = 0
) (
   input logic                        clk,
   input logic                        rst,
   factorization_checker_seq_if.slave bus
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CHECK
   } state_t;

   state_t         state_q, state_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] o_q, o_d;
   logic           nt_q, nt_d;
   logic [CW-1:0]  count_q, count_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           res_q, res_d;
   logic [2*W-1:0] product_q, product_d;

   // State and datapath registers; reset clears everything, aborting any run silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         o_q       <= '0;
         nt_q      <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         res_q     <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         o_q       <= o_d;
         nt_q      <= nt_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         res_q     <= res_d;
         product_q <= product_d;
      end
   end

   // Next-state and datapath: accept in IDLE, one shift-add step per RUN cycle, compare in CHECK.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      o_d       = o_q;
      nt_d      = nt_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      res_d     = res_q;
      product_d = product_q;

      unique case (state_q)
         S_IDLE: begin
            // busy_q still set here means this is the done cycle: drop busy and
            // ignore any start until the following cycle.
            if (busy_q) begin
               busy_d = 1'b0;
            end else if (bus.start) begin
               mcand_d  = {{W{1'b0}}, bus.i1};
               mplier_d = bus.i2;
               acc_d    = '0;
               o_d      = bus.o;
               nt_d     = (bus.i1 != W'(1)) && (bus.i2 != W'(1));
               count_d  = '0;
               busy_d   = 1'b1;
               if ((EARLY_EXIT != 0) && (bus.i2 == '0)) state_d = S_CHECK;
               else                                     state_d = S_RUN;
            end
         end

         S_RUN: begin
            // mcand is 2W wide and only ever gets W shifts, so the sum never overflows.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if ((count_q == CW'(W - 1)) || ((EARLY_EXIT != 0) && (mplier_d == '0)))
               state_d = S_CHECK;
         end

         S_CHECK: begin
            res_d     = (acc_q == o_q) && (nt_q || (NONTRIVIAL == 0));
            product_d = acc_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.res     = res_q;
   assign bus.product = product_q;

endmodule
